tick_scheduler: RTL and testbench

Synchronous controller for the divided-clock resource of the counter/adder design. It replaces the ripple T-flip-flop chain with a single-clock up-counter that generates a one-cycle `tick` every 2^(k+1) `clk` cycles. It supports run/stop sequencing and glitch-free reconfiguration of k through a valid/ready handshake. Each tick is granted round-robin to one of NREQ requesters, so one time base is shared across consumers.

---
 rtl/tick_scheduler.sv | 149 ++++++++++++++
 tb/tb_tick_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tick_scheduler                                                             |
// | Single-clock divided time base: one tick every 2^(k+1) cycles, run/stop    |
// | control, glitch-free k reconfiguration, round-robin tick grant.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tick_scheduler #(
    parameter int CNT_W = 12,
    parameter int NREQ  = 4,
    parameter int K_RST = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_sel,
    output logic             cfg_ready,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             tick,
    output logic             running,
    output logic [3:0]       cur_sel,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]       C_MAX_SEL = 4'(CNT_W - 1);
    localparam logic [3:0]       C_K_RST   = 4'(K_RST);
    localparam logic [PTR_W-1:0] C_LAST    = PTR_W'(NREQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic             pending;
    logic [3:0]       pend_sel;
    logic [PTR_W-1:0] ptr;

    logic [CNT_W-1:0] term;
    logic             at_term;
    logic             xfer;
    logic             boundary;
    logic [3:0]       sel_clamped;
    logic             found;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] next_ptr;
    int               scan_pos;

    // Terminal value 2^(k+1)-1 is a run of k+1 ones, so it never overflows CNT_W.
    always_comb begin
        term = '0;
        for (int i = 0; i < CNT_W; i++) begin
            term[i] = (i <= int'(cur_sel));
        end
    end

    assign at_term     = (count == term);
    assign tick        = (state == RUN) && at_term;
    assign running     = (state == RUN);
    assign cfg_ready   = !pending;
    assign xfer        = cfg_valid && cfg_ready;
    assign boundary    = stop || at_term;
    assign sel_clamped = (cfg_sel > C_MAX_SEL) ? C_MAX_SEL : cfg_sel;

    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        scan_pos = 0;
        scan_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan_pos = int'(ptr) + off;
            if (scan_pos >= NREQ) begin
                scan_pos = scan_pos - NREQ;
            end
            scan_idx = PTR_W'(scan_pos);
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                gidx  = scan_idx;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (tick && found) begin
            gnt[gidx] = 1'b1;
        end
    end

    assign next_ptr = (gidx == C_LAST) ? '0 : gidx + PTR_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            count    <= '0;
            cur_sel  <= C_K_RST;
            pending  <= 1'b0;
            pend_sel <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (xfer) begin
                        cur_sel <= sel_clamped;
                    end
                    if (start && !stop) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (at_term) begin
                        count <= '0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                    // k only changes at a period boundary (wrap or stop) so no period is truncated.
                    if (pending && boundary) begin
                        cur_sel <= pend_sel;
                        pending <= 1'b0;
                    end else if (xfer) begin
                        if (boundary) begin
                            cur_sel <= sel_clamped;
                        end else begin
                            pending  <= 1'b1;
                            pend_sel <= sel_clamped;
                        end
                    end
                    if (tick && found) begin
                        ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tick_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tick_scheduler                                                          |
// | Directed scenarios plus randomized run against a period-level model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tick_scheduler;

    localparam int CNT_W = 12;
    localparam int NREQ  = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [3:0]       cfg_sel = '0;
    logic [NREQ-1:0]  req = '0;
    logic             cfg_ready;
    logic [NREQ-1:0]  gnt;
    logic             tick;
    logic             running;
    logic [3:0]       cur_sel;
    logic [CNT_W-1:0] count;

    int total = 0;
    int bad   = 0;

    tick_scheduler #(.CNT_W(CNT_W), .NREQ(NREQ), .K_RST(10)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_ready (cfg_ready),
        .req       (req),
        .gnt       (gnt),
        .tick      (tick),
        .running   (running),
        .cur_sel   (cur_sel),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int maxc, output int n);
        #1;
        n = 0;
        while (!tick && n < maxc) begin
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        start = 0; stop = 0; cfg_valid = 0; req = '0;
        #2 rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic start_run();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic stop_run();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic set_k(input int k);
        cfg_valid = 1'b1; cfg_sel = 4'(k); step(); cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rstn = 1'b0;
        #1;
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %0d want 0", running); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0d want 0", tick); end
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready: got %0d want 1", cfg_ready); end
        total++; if (cur_sel !== 4'd10) begin bad++; $display("FAIL reset_cur_sel: got %0d want 10", cur_sel); end
        total++; if (count !== 12'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_default_period();
        int n;
        start_run();
        total++; if (running !== 1'b1 || count !== 12'd0) begin bad++; $display("FAIL start_state: running=%0d count=%0d want 1/0", running, count); end
        wait_tick(3000, n);
        total++; if (n !== 2047) begin bad++; $display("FAIL default_first_tick: edges=%0d want 2047", n); end
        total++; if (gnt !== 4'b0) begin bad++; $display("FAIL default_gnt_noreq: got %b want 0000", gnt); end
        step();
        wait_tick(3000, n);
        total++; if (n !== 2047) begin bad++; $display("FAIL default_second_tick: edges=%0d want 2047", n); end
        stop_run();
    endtask

    task automatic test_k0();
        stop_run();
        set_k(0);
        total++; if (cur_sel !== 4'd0) begin bad++; $display("FAIL k0_load: got %0d want 0", cur_sel); end
        start_run();
        #1;
        for (int i = 0; i < 8; i++) begin
            total++; if (tick !== ((i % 2) == 1)) begin bad++; $display("FAIL k0_tick_%0d: got %0d want %0d", i, tick, (i % 2)); end
            step();
        end
    endtask

    task automatic test_k11();
        int n;
        stop_run();
        set_k(11);
        start_run();
        wait_tick(5000, n);
        total++; if (n !== 4095) begin bad++; $display("FAIL k11_period: edges=%0d want 4095", n); end
        total++; if (count !== 12'd4095) begin bad++; $display("FAIL k11_count: got %0d want 4095", count); end
        step();
        total++; if (count !== 12'd0) begin bad++; $display("FAIL k11_wrap: got %0d want 0", count); end
        stop_run();
    endtask

    task automatic test_reconfig();
        int n;
        set_k(3);
        start_run();
        repeat (5) step();
        total++; if (count !== 12'd5) begin bad++; $display("FAIL reconf_count5: got %0d want 5", count); end
        cfg_valid = 1'b1; cfg_sel = 4'd1;
        #1;
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reconf_ready_pre: got %0d want 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0 || cur_sel !== 4'd3) begin bad++; $display("FAIL reconf_accept: ready=%0d sel=%0d want 0/3", cfg_ready, cur_sel); end
        n = 0;
        while (count != 12'd15 && n < 20) begin
            total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reconf_ready_low: got %0d want 0 at count %0d", cfg_ready, count); end
            step();
            n++;
        end
        total++; if (tick !== 1'b1 || cfg_ready !== 1'b0) begin bad++; $display("FAIL reconf_term: tick=%0d ready=%0d want 1/0", tick, cfg_ready); end
        step();
        total++; if (count !== 12'd0 || cfg_ready !== 1'b1 || cur_sel !== 4'd1) begin
            bad++; $display("FAIL reconf_applied: count=%0d ready=%0d sel=%0d want 0/1/1", count, cfg_ready, cur_sel); end
        wait_tick(20, n);
        total++; if (n !== 3) begin bad++; $display("FAIL reconf_new_period: edges=%0d want 3", n); end
        stop_run();
        set_k(15);
        total++; if (cur_sel !== 4'd11) begin bad++; $display("FAIL clamp: got %0d want 11", cur_sel); end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        set_k(0);
        req = 4'b1111;
        start_run();
        for (int t = 0; t < 5; t++) begin
            wait_tick(10, n);
            total++; if (gnt !== 4'(1 << (t % 4))) begin bad++; $display("FAIL rr_all_%0d: got %b want %b", t, gnt, 4'(1 << (t % 4))); end
            step();
        end
        req = 4'b0100;
        for (int t = 0; t < 3; t++) begin
            wait_tick(10, n);
            total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rr_single_%0d: got %b want 0100", t, gnt); end
            step();
        end
        req = 4'b0000;
        for (int t = 0; t < 2; t++) begin
            wait_tick(10, n);
            total++; if (tick !== 1'b1 || gnt !== 4'b0) begin bad++; $display("FAIL noreq_%0d: tick=%0d gnt=%b want 1/0000", t, tick, gnt); end
            step();
        end
        req = 4'b1111;
        wait_tick(10, n);
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL noreq_ptr_held: got %b want 1000", gnt); end
        step();
        req = '0;
        stop_run();
    endtask

    task automatic test_control();
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        total++; if (running !== 1'b0 || count !== 12'd0) begin bad++; $display("FAIL start_stop_idle: running=%0d count=%0d want 0/0", running, count); end
        set_k(3);
        start_run();
        repeat (7) step();
        total++; if (count !== 12'd7) begin bad++; $display("FAIL stop_mid_count: got %0d want 7", count); end
        stop_run();
        total++; if (running !== 1'b0 || count !== 12'd0) begin bad++; $display("FAIL stop_mid: running=%0d count=%0d want 0/0", running, count); end
        for (int i = 0; i < 20; i++) begin
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL stop_no_tick_%0d: got %0d want 0", i, tick); end
            step();
        end
    endtask

    task automatic test_reset_pending();
        start_run();
        repeat (2) step();
        cfg_valid = 1'b1; cfg_sel = 4'd1; step(); cfg_valid = 1'b0;
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rstpend_pending: ready=%0d want 0", cfg_ready); end
        #2 rstn = 1'b0;
        #1;
        total++; if (cur_sel !== 4'd10 || cfg_ready !== 1'b1 || tick !== 1'b0 || count !== 12'd0 || running !== 1'b0) begin
            bad++; $display("FAIL rstpend_async: sel=%0d ready=%0d tick=%0d count=%0d run=%0d want 10/1/0/0/0", cur_sel, cfg_ready, tick, count, running); end
        step();
        rstn = 1'b1;
        step();
        start_run();
        repeat (20) step();
        total++; if (cur_sel !== 4'd10) begin bad++; $display("FAIL rstpend_discard: sel=%0d want 10", cur_sel); end
        stop_run();
    endtask

    task automatic test_random();
        bit m_run;
        int m_cnt, m_k, m_ptr, term, eg, cl, idx;
        int pendq[$];
        bit xfer, bound;
        logic [NREQ-1:0] exp_gnt;
        bit exp_tick;
        do_reset();
        m_run = 0; m_cnt = 0; m_k = 10; m_ptr = 0; pendq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_sel   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 3));
            req       = 4'($urandom_range(0, 15));
            #1;
            term = (1 << (m_k + 1)) - 1;
            exp_tick = m_run && (m_cnt == term);
            eg = -1;
            if (exp_tick) begin
                for (int off = 0; off < NREQ; off++) begin
                    idx = (m_ptr + off) % NREQ;
                    if (eg < 0 && req[idx]) eg = idx;
                end
            end
            exp_gnt = (eg < 0) ? '0 : 4'(1 << eg);
            total++; if (tick !== exp_tick || gnt !== exp_gnt) begin
                bad++; $display("FAIL rand_tick_gnt cyc %0d: tick=%0d gnt=%b want %0d/%b", cyc, tick, gnt, exp_tick, exp_gnt); end
            total++; if (running !== m_run || count !== 12'(m_cnt)) begin
                bad++; $display("FAIL rand_run_count cyc %0d: run=%0d count=%0d want %0d/%0d", cyc, running, count, m_run, m_cnt); end
            total++; if (cur_sel !== 4'(m_k) || cfg_ready !== (pendq.size() == 0)) begin
                bad++; $display("FAIL rand_cfg cyc %0d: sel=%0d ready=%0d want %0d/%0d", cyc, cur_sel, cfg_ready, m_k, (pendq.size() == 0)); end
            xfer = cfg_valid && (pendq.size() == 0);
            cl = (cfg_sel > 4'd11) ? 11 : int'(cfg_sel);
            if (!m_run) begin
                if (xfer) m_k = cl;
                m_run = start && !stop;
                m_cnt = 0;
            end else begin
                bound = stop || (m_cnt == term);
                if (pendq.size() > 0 && bound) m_k = pendq.pop_front();
                else if (xfer) begin
                    if (bound) m_k = cl;
                    else pendq.push_back(cl);
                end
                if (eg >= 0) m_ptr = (eg + 1) % NREQ;
                m_cnt = stop ? 0 : (m_cnt + 1) % (term + 1);
                m_run = !stop;
            end
            step();
        end
        start = 0; stop = 0; cfg_valid = 0; req = '0;
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_k0();
        test_k11();
        test_reconfig();
        test_round_robin();
        test_control();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
